msg_serializer: RTL and testbench



---
 rtl/msg_serializer.sv | 150 +++++++++++++++
 tb/tb_msg_serializer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_serializer.sv
// Buffers whole messages (up to 32 bytes) in a small FIFO and replays each one as 64-bit Avalon-ST beats.
// Push to first beat: 1 cycle. Sink backpressure holds every output; a full FIFO drops whole incoming messages and counts them.
module msg_serializer #(
    parameter int DATA_WIDTH        = 64,
    parameter int OUTPUT_WIDTH      = 256,
    parameter int OUTPUT_MASK_WIDTH = 32,
    parameter int MSG_DEPTH         = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [OUTPUT_WIDTH-1:0]      in_data,
    input  logic [OUTPUT_MASK_WIDTH-1:0] in_bytemask,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_startofpayload,
    output logic                         out_endofpayload,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [2:0]                   out_empty,
    output logic                         drop_pulse,
    output logic [7:0]                   drop_count,
    output logic [$clog2(MSG_DEPTH):0]   fifo_level
);

    localparam int BPB       = DATA_WIDTH / 8;
    localparam int MAX_BEATS = OUTPUT_WIDTH / DATA_WIDTH;
    localparam int BEAT_W    = $clog2(MAX_BEATS);
    localparam int EMP_W     = $clog2(BPB);
    localparam int LEN_W     = $clog2(OUTPUT_MASK_WIDTH) + 1;
    localparam int PTR_W     = $clog2(MSG_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    logic [OUTPUT_WIDTH-1:0] data_mem [MSG_DEPTH];
    logic [LEN_W-1:0]        len_mem  [MSG_DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              drop_pulse_q, drop_pulse_d;
    logic [7:0]        drop_count_q, drop_count_d;

    logic [LEN_W-1:0]        in_len;
    logic [OUTPUT_WIDTH-1:0] head_data;
    logic [LEN_W-1:0]        head_len;
    logic [LEN_W-1:0]        neg_len;
    logic [BEAT_W-1:0]       last_beat;
    logic [DATA_WIDTH-1:0]   beat_bytes;
    logic                    is_last;
    logic                    full;
    logic                    beat_fire;
    logic                    eop_pop;
    logic                    push_req;
    logic                    push;
    logic                    drop;

    // Length follows the highest set mask bit; holes below it are treated as valid bytes.
    always_comb begin
        in_len = '0;
        for (int k = 0; k < OUTPUT_MASK_WIDTH; k++) begin
            if (in_bytemask[k]) in_len = LEN_W'(k + 1);
        end
    end

    assign head_data  = data_mem[rd_ptr_q];
    assign head_len   = len_mem[rd_ptr_q];
    assign last_beat  = BEAT_W'((head_len - LEN_W'(1)) >> EMP_W);
    assign neg_len    = LEN_W'(0) - head_len;
    assign beat_bytes = head_data[beat_q*DATA_WIDTH +: DATA_WIDTH];

    assign full      = (count_q == CNT_W'(MSG_DEPTH));
    assign out_valid = (count_q != '0);
    assign is_last   = (beat_q == last_beat);
    assign beat_fire = out_valid && out_ready;
    assign eop_pop   = beat_fire && is_last;
    assign push_req  = in_valid && (in_bytemask != '0);
    assign push      = push_req && (!full || eop_pop);
    assign drop      = push_req && !push;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            beat_q       <= '0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            beat_q       <= beat_d;
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage needs no reset: pointers and level alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= in_data;
            len_mem[wr_ptr_q]  <= in_len;
        end
    end

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        beat_d       = beat_q;
        drop_pulse_d = drop;
        drop_count_d = drop_count_q;
        if (eop_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            beat_d   = '0;
        end else if (beat_fire) begin
            beat_d = beat_q + BEAT_W'(1);
        end
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        case ({push, eop_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (drop && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;
    end

    // First symbol goes to the top byte lane; lanes past the message length read as zero.
    always_comb begin
        out_data           = '0;
        out_startofpayload = 1'b0;
        out_endofpayload   = 1'b0;
        out_empty          = '0;
        if (out_valid) begin
            for (int j = 0; j < BPB; j++) begin
                if (int'(beat_q) * BPB + j < int'(head_len)) begin
                    out_data[DATA_WIDTH-1-8*j -: 8] = beat_bytes[8*j +: 8];
                end
            end
            out_startofpayload = (beat_q == '0);
            out_endofpayload   = is_last;
            if (is_last) out_empty = 3'(neg_len[EMP_W-1:0]);
        end
    end

    assign drop_pulse = drop_pulse_q;
    assign drop_count = drop_count_q;
    assign fifo_level = count_q;

endmodule

// File: tb/tb_msg_serializer.sv
// Randomized and directed stimulus against a message-level reference model; a negedge monitor scores every cycle.
module tb_msg_serializer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [255:0] in_data;
    logic [31:0]  in_bytemask;
    logic         out_valid;
    logic         out_ready;
    logic         out_startofpayload;
    logic         out_endofpayload;
    logic [63:0]  out_data;
    logic [2:0]   out_empty;
    logic         drop_pulse;
    logic [7:0]   drop_count;
    logic [2:0]   fifo_level;

    msg_serializer #(
        .DATA_WIDTH(64), .OUTPUT_WIDTH(256), .OUTPUT_MASK_WIDTH(32), .MSG_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_bytemask(in_bytemask), .out_valid(out_valid), .out_ready(out_ready),
        .out_startofpayload(out_startofpayload), .out_endofpayload(out_endofpayload),
        .out_data(out_data), .out_empty(out_empty), .drop_pulse(drop_pulse),
        .drop_count(drop_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int    n_pass  = 0;
    int    n_total = 0;
    beat_t exp_q[$];
    int    mlevel   = 0;
    int    mdrops   = 0;
    bit    mpulse   = 0;
    bit    post_rst = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Expected beats straight from the byte-stream view of a message.
    function automatic void model_push(input logic [255:0] d, input logic [31:0] m);
        int    len = 0;
        int    nb;
        beat_t bt;
        for (int k = 0; k < 32; k++) if (m[k]) len = k + 1;
        nb = (len + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            bt.data = '0;
            for (int j = 0; j < 8; j++) begin
                int idx = 8 * b + j;
                bt.data = bt.data << 8;
                if (idx < len) bt.data[7:0] = d[8*idx +: 8];
            end
            bt.sop   = (b == 0);
            bt.eop   = (b == nb - 1);
            bt.empty = bt.eop ? 3'(nb * 8 - len) : 3'd0;
            exp_q.push_back(bt);
        end
    endfunction

    always @(negedge clk) begin
        bit    eop_pop;
        beat_t e;
        if (reset) begin
            exp_q.delete();
            mlevel   = 0;
            mdrops   = 0;
            mpulse   = 0;
            post_rst = 1;
        end else begin
            chk("fifo_level", 64'(fifo_level), 64'(mlevel));
            chk("drop_pulse", 64'(drop_pulse), 64'(mpulse));
            chk("drop_count", 64'(drop_count), 64'(mdrops));
            chk("out_valid",  64'(out_valid),  64'(mlevel != 0));
            if (post_rst) begin
                chk("rst_out_data", out_data, 64'd0);
                chk("rst_sop", 64'(out_startofpayload), 64'd0);
                chk("rst_eop", 64'(out_endofpayload), 64'd0);
                chk("rst_empty", 64'(out_empty), 64'd0);
                post_rst = 0;
            end
            eop_pop = 0;
            if (mlevel != 0) begin
                e = exp_q[0];
                chk("beat_data",  out_data, e.data);
                chk("beat_sop",   64'(out_startofpayload), 64'(e.sop));
                chk("beat_eop",   64'(out_endofpayload), 64'(e.eop));
                chk("beat_empty", 64'(out_empty), 64'(e.empty));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    eop_pop = e.eop;
                end
            end
            mpulse = 0;
            if (in_valid && in_bytemask != 0) begin
                if (mlevel < DEPTH || eop_pop) begin
                    model_push(in_data, in_bytemask);
                    mlevel++;
                end else begin
                    mpulse = 1;
                    if (mdrops < 255) mdrops++;
                end
            end
            if (eop_pop) mlevel--;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [255:0] d, input logic [31:0] m);
        in_valid    = 1'b1;
        in_data     = d;
        in_bytemask = m;
        tick();
        in_valid    = 1'b0;
    endtask

    function automatic logic [255:0] rand_data();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [31:0] len_mask(input int len);
        logic [32:0] one = 33'd1;
        return 32'((one << len) - 33'd1);
    endfunction

    // Random mask: top set bit fixes the length, lower bits sometimes holey.
    function automatic logic [31:0] rand_mask();
        int len;
        logic [31:0] m;
        if ($urandom_range(0, 9) == 0) return 32'd0;
        len = $urandom_range(1, 32);
        m = len_mask(len);
        if ($urandom_range(0, 2) == 0) m = (m & $urandom) | (32'd1 << (len - 1));
        return m;
    endfunction

    initial begin
        logic [255:0] d;
        int waited;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_bytemask = '0; out_ready = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);

        // 10-byte message 01..0A
        out_ready = 1'b1;
        d = '0;
        for (int k = 0; k < 10; k++) d[8*k +: 8] = 8'(k + 1);
        send(d, 32'h3FF);
        tick(4);

        // full 32-byte and 3-byte messages, plus an ignored zero mask
        send(rand_data(), 32'hFFFF_FFFF);
        send(rand_data(), 32'h7);
        send(rand_data(), 32'h0);
        tick(8);

        // backpressure toggling through a 4-beat message
        send(rand_data(), 32'hFFFF_FFFF);
        for (int i = 0; i < 12; i++) begin
            out_ready = ~out_ready;
            tick();
        end
        out_ready = 1'b1;
        tick(4);

        // overflow: 5 pushes into a stalled FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(rand_data(), len_mask($urandom_range(1, 32)));
        tick(2);
        out_ready = 1'b1;
        tick(25);

        // full FIFO, push coincident with the head's eop transfer
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(rand_data(), len_mask($urandom_range(1, 8)));
        tick();
        out_ready = 1'b1;
        send(rand_data(), len_mask(20));
        out_ready = 1'b0;
        tick(3);
        out_ready = 1'b1;
        tick(20);

        // reset during beat1 of a 3-beat message
        send(rand_data(), len_mask(20));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send(rand_data(), len_mask(12));
        tick(6);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 1) == 1) send(rand_data(), rand_mask());
            else tick();
        end

        // drop counter saturation
        out_ready = 1'b0;
        for (int i = 0; i < 270; i++) send(rand_data(), len_mask($urandom_range(1, 32)));
        tick(2);
        out_ready = 1'b1;

        waited = 0;
        while (fifo_level != 0 && waited < 500) begin
            tick();
            waited++;
        end
        chk("drain_done", 64'(fifo_level), 64'd0);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
